// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle for instruction_fetch_unit: memory address/data,
// branch redirect, and the IF/ID valid/ready output stage.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the sticky misalign flag.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 64,
  parameter int INS_W  = 32
);
  logic [ADDR_W-1:0] ins_add;
  logic [INS_W-1:0]  ins;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INS_W-1:0]  if_ins;
  logic [31:0]       fetch_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              misalign;

  // Fetch unit side: drives the address and the decode-facing stage
  modport master (
    output ins_add,
    input  ins,
    input  branch_taken,
    input  branch_target,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_ins,
    output fetch_cnt,
    output misalign
  );

  // Environment side: memory, branch resolution and decode
  modport slave (
    input  ins_add,
    output ins,
    output branch_taken,
    output branch_target,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_ins,
    input  fetch_cnt,
    input  misalign
  );
`else
  // Fetch unit side: drives the address and the decode-facing stage
  modport master (
    output ins_add,
    input  ins,
    input  branch_taken,
    input  branch_target,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_ins,
    output fetch_cnt
  );

  // Environment side: memory, branch resolution and decode
  modport slave (
    input  ins_add,
    output ins,
    output branch_taken,
    output branch_target,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_ins,
    input  fetch_cnt
  );
`endif
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register plus IF/ID output register.
// The PC drives instruction memory directly; the instruction returned
// combinationally is captured together with its PC and offered to decode
// through a valid/ready handshake. Branches redirect the PC and flush the
// presented instruction, leaving a one-cycle bubble.
// Optional macro FETCH_MISALIGN_TRAP_EN: a branch to a target that is not
// 4-byte aligned sets a sticky misalign flag and halts fetching until reset.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INS_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instruction_fetch_unit_if.master  bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [INS_W-1:0]  if_ins_q, if_ins_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic              run;
  logic              load;
  logic              accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0] state_q, state_d;
  logic       misalign_q, misalign_d;

  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif

  // A new instruction enters the output stage when the stage is empty or
  // being drained this cycle; a completed handshake is counted separately.
  assign load   = (!if_valid_q || bus.if_ready) && run;
  assign accept = if_valid_q && bus.if_ready;

  // Next-state: branch redirect beats sequential load, which beats stall
  always_comb begin
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_ins_d    = if_ins_q;
    fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d     = state_q;
    misalign_d  = misalign_q;
`endif
    if (bus.branch_taken && run) begin
      pc_d       = bus.branch_target;
      if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.branch_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = HALT;
      end
`endif
    end else if (load) begin
      if_pc_d    = pc_q;
      if_ins_d   = bus.ins;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_INC;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_ins_q    <= '0;
      fetch_cnt_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q     <= RUN;
      misalign_q  <= 1'b0;
`endif
    end else begin
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_ins_q    <= if_ins_d;
      fetch_cnt_q <= fetch_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q     <= state_d;
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign bus.ins_add   = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_ins    = if_ins_q;
  assign bus.fetch_cnt = fetch_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign  = misalign_q;
`endif

endmodule
